alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between two requesters. Each operation moves
// through IDLE (arbitrate / accept), ISSUE (drive the ALU, capture its result)
// and RESP (present the response to the owner until it is consumed), giving
// one operation per three cycles when the response is taken at once.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   req_valid_k_i / req_ready_k_o  request handshake, k = 0,1
//   req_ctrl_k_i, req_src1/2_k_i   op code and operands of requester k
//   rsp_valid_k_o / rsp_ready_k_i  response handshake, k = 0,1
//   rsp_result_o, rsp_zero_o       shared response data
//   rsp_err_o                      request carried an illegal op code
//   alu_src1/2_o, alu_ctrl_o       operands and op code towards the ALU
//   alu_result_i, alu_zero_i       combinational ALU result
//
// Configuration
//   ALU_ARB_RR_EN  defined   : round-robin arbitration on contention
//                  undefined : fixed priority, port 0 wins contention
module alu_arbiter (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_0_i,
  output logic        req_ready_0_o,
  input  logic [3:0]  req_ctrl_0_i,
  input  logic [31:0] req_src1_0_i,
  input  logic [31:0] req_src2_0_i,
  output logic        rsp_valid_0_o,
  input  logic        rsp_ready_0_i,
  input  logic        req_valid_1_i,
  output logic        req_ready_1_o,
  input  logic [3:0]  req_ctrl_1_i,
  input  logic [31:0] req_src1_1_i,
  input  logic [31:0] req_src2_1_i,
  output logic        rsp_valid_1_o,
  input  logic        rsp_ready_1_i,
  output logic [31:0] rsp_result_o,
  output logic        rsp_zero_o,
  output logic        rsp_err_o,
  output logic [31:0] alu_src1_o,
  output logic [31:0] alu_src2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_result_i,
  input  logic        alu_zero_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [3:0] OP_ADD = 4'b0010;

  // True for the op codes the ALU implements.
  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100: op_legal = 1'b1;
      default:                                              op_legal = 1'b0;
    endcase
  endfunction

  state_e      state_q;
  logic        owner_q;      // 0: port 0 owns the transaction, 1: port 1
  logic        err_pend_q;   // illegal op seen at accept, published with result
  logic [3:0]  alu_ctrl_q;
  logic [31:0] alu_src1_q;
  logic [31:0] alu_src2_q;
  logic [31:0] rsp_result_q;
  logic        rsp_zero_q;
  logic        rsp_err_q;
  logic        rsp_valid_0_q;
  logic        rsp_valid_1_q;

  logic        prio1_s;      // port 1 wins contention this cycle
  logic        accept_s;
  logic        grant_s;      // port id being accepted
  logic [3:0]  sel_ctrl_s;
  logic [31:0] sel_src1_s;
  logic [31:0] sel_src2_s;
  logic        rsp_take_s;

`ifdef ALU_ARB_RR_EN
  logic        ptr_q;

  // Round-robin: contention goes to the port the pointer names.
  always_comb begin
    prio1_s = ptr_q;
  end
`else
  // Fixed priority: port 0 always wins contention.
  always_comb begin
    prio1_s = 1'b0;
  end
`endif

  // Arbitration and operand selection; requests are only accepted in IDLE.
  always_comb begin
    accept_s = 1'b0;
    grant_s  = 1'b0;
    if (state_q == IDLE) begin
      if (req_valid_0_i && req_valid_1_i) begin
        accept_s = 1'b1;
        grant_s  = prio1_s;
      end else if (req_valid_1_i) begin
        accept_s = 1'b1;
        grant_s  = 1'b1;
      end else if (req_valid_0_i) begin
        accept_s = 1'b1;
        grant_s  = 1'b0;
      end else begin
        accept_s = 1'b0;
        grant_s  = 1'b0;
      end
    end else begin
      accept_s = 1'b0;
      grant_s  = 1'b0;
    end
    if (grant_s) begin
      sel_ctrl_s = req_ctrl_1_i;
      sel_src1_s = req_src1_1_i;
      sel_src2_s = req_src2_1_i;
    end else begin
      sel_ctrl_s = req_ctrl_0_i;
      sel_src1_s = req_src1_0_i;
      sel_src2_s = req_src2_0_i;
    end
    if (owner_q) begin
      rsp_take_s = rsp_ready_1_i;
    end else begin
      rsp_take_s = rsp_ready_0_i;
    end
  end

  // Ready must answer valid within the same cycle, so it is decoded here.
  always_comb begin
    req_ready_0_o = accept_s & ~grant_s;
    req_ready_1_o = accept_s &  grant_s;
  end

  // Transaction FSM with all response and ALU-facing outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      err_pend_q    <= 1'b0;
      alu_ctrl_q    <= 4'd0;
      alu_src1_q    <= 32'd0;
      alu_src2_q    <= 32'd0;
      rsp_result_q  <= 32'd0;
      rsp_zero_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
      ptr_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            owner_q    <= grant_s;
            // Illegal codes are executed as ADD and flagged in the response.
            alu_ctrl_q <= op_legal(sel_ctrl_s) ? sel_ctrl_s : OP_ADD;
            err_pend_q <= ~op_legal(sel_ctrl_s);
            alu_src1_q <= sel_src1_s;
            alu_src2_q <= sel_src2_s;
            state_q    <= ISSUE;
`ifdef ALU_ARB_RR_EN
            ptr_q      <= ~grant_s;
`endif
          end
        end
        ISSUE: begin
          rsp_result_q  <= alu_result_i;
          rsp_zero_q    <= alu_zero_i;
          rsp_err_q     <= err_pend_q;
          // ALU inputs return to zero once the result has been captured.
          alu_ctrl_q    <= 4'd0;
          alu_src1_q    <= 32'd0;
          alu_src2_q    <= 32'd0;
          rsp_valid_0_q <= ~owner_q;
          rsp_valid_1_q <= owner_q;
          state_q       <= RESP;
        end
        RESP: begin
          if (rsp_take_s) begin
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          rsp_valid_0_q <= 1'b0;
          rsp_valid_1_q <= 1'b0;
          state_q       <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_0_o = rsp_valid_0_q;
  assign rsp_valid_1_o = rsp_valid_1_q;
  assign rsp_result_o  = rsp_result_q;
  assign rsp_zero_o    = rsp_zero_q;
  assign rsp_err_o     = rsp_err_q;
  assign alu_ctrl_o    = alu_ctrl_q;
  assign alu_src1_o    = alu_src1_q;
  assign alu_src2_o    = alu_src2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_0, req_ready_0, rsp_valid_0, rsp_ready_0;
  logic        req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1;
  logic [3:0]  req_ctrl_0, req_ctrl_1;
  logic [31:0] req_src1_0, req_src2_0, req_src1_1, req_src2_1;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [31:0] alu_src1, alu_src2, alu_result;
  logic [3:0]  alu_ctrl;
  logic        alu_zero;

  int checks   = 0;
  int failures = 0;
  logic exp_ptr = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_0_i(req_valid_0), .req_ready_0_o(req_ready_0),
    .req_ctrl_0_i(req_ctrl_0), .req_src1_0_i(req_src1_0), .req_src2_0_i(req_src2_0),
    .rsp_valid_0_o(rsp_valid_0), .rsp_ready_0_i(rsp_ready_0),
    .req_valid_1_i(req_valid_1), .req_ready_1_o(req_ready_1),
    .req_ctrl_1_i(req_ctrl_1), .req_src1_1_i(req_src1_1), .req_src2_1_i(req_src2_1),
    .rsp_valid_1_o(rsp_valid_1), .rsp_ready_1_i(rsp_ready_1),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err),
    .alu_src1_o(alu_src1), .alu_src2_o(alu_src2), .alu_ctrl_o(alu_ctrl),
    .alu_result_i(alu_result), .alu_zero_i(alu_zero)
  );

  // Combinational ALU attached to the arbiter; unknown codes yield 0.
  always_comb begin
    alu_result = 32'd0;
    if (alu_ctrl == 4'b0000)      alu_result = alu_src1 & alu_src2;
    else if (alu_ctrl == 4'b0001) alu_result = alu_src1 | alu_src2;
    else if (alu_ctrl == 4'b0010) alu_result = alu_src1 + alu_src2;
    else if (alu_ctrl == 4'b0110) alu_result = alu_src1 - alu_src2;
    else if (alu_ctrl == 4'b0111) alu_result = {31'd0, ($signed(alu_src1) < $signed(alu_src2))};
    else if (alu_ctrl == 4'b1100) alu_result = ~(alu_src1 | alu_src2);
    else                          alu_result = 32'd0;
    alu_zero = (alu_result == 32'd0);
  end

  // Reference: what the requester should get back for an op.
  function automatic logic is_legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
  endfunction

  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h6:    return a - b;
      4'h7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'hC:    return ~(a | b);
      default: return a + b;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic clear_reqs();
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
  endtask

  task automatic set_req(input int port, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    if (port == 1) begin
      req_valid_1 = 1'b1; req_ctrl_1 = c; req_src1_1 = a; req_src2_1 = b;
    end else begin
      req_valid_0 = 1'b1; req_ctrl_0 = c; req_src1_0 = a; req_src2_0 = b;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_reqs();
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_ptr = 1'b0;
  endtask

  // One full transaction on one port with the response taken at once.
  task automatic do_txn(input string nm, input int port, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ez, input logic ee);
    int n;
    @(negedge clk);
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    set_req(port, c, a, b);
    #1;
    n = 0;
    while (!((port == 1) ? req_ready_1 : req_ready_0) && n < 8) begin
      @(negedge clk); n++;
    end
    chk({nm, "_ready"}, {31'd0, (port == 1) ? req_ready_1 : req_ready_0}, 32'd1);
    chk({nm, "_other_ready"}, {31'd0, (port == 1) ? req_ready_0 : req_ready_1}, 32'd0);
    @(negedge clk);                     // ISSUE
    clear_reqs();
    chk({nm, "_alu_ctrl"}, {28'd0, alu_ctrl}, {28'd0, is_legal(c) ? c : 4'b0010});
    chk({nm, "_alu_src1"}, alu_src1, a);
    chk({nm, "_issue_ready"}, {30'd0, req_ready_0, req_ready_1}, 32'd0);
    @(negedge clk);                     // RESP, accept + 2
    chk({nm, "_rsp_valid"}, {30'd0, rsp_valid_0, rsp_valid_1}, (port == 1) ? 32'd1 : 32'd2);
    chk({nm, "_result"}, rsp_result, er);
    chk({nm, "_zero_err"}, {30'd0, rsp_zero, rsp_err}, {30'd0, ez, ee});
    @(negedge clk);                     // back in IDLE
    chk({nm, "_idle_valid"}, {30'd0, rsp_valid_0, rsp_valid_1}, 32'd0);
    chk({nm, "_idle_alu"}, alu_src1 | alu_src2 | {28'd0, alu_ctrl}, 32'd0);
    chk({nm, "_hold_result"}, rsp_result, er);
  endtask

  typedef struct {
    int          port;
    logic [3:0]  ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int n;
    logic [3:0]  rc;
    logic [31:0] ra, rb, rr;
    int          rp;
    logic        g;

    vecs[0] = '{0, 4'b0010, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0};
    vecs[1] = '{1, 4'b0111, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0};
    vecs[2] = '{1, 4'b0110, 32'd9,          32'd9,          32'd0,          1'b1, 1'b0};
    vecs[3] = '{0, 4'b0101, 32'd3,          32'd4,          32'd7,          1'b0, 1'b1};
    vecs[4] = '{0, 4'b0000, 32'h0000_F0F0,  32'h0000_0FF0,  32'h0000_00F0,  1'b0, 1'b0};
    vecs[5] = '{1, 4'b0001, 32'h1200_0000,  32'h0000_0034,  32'h1200_0034,  1'b0, 1'b0};
    vecs[6] = '{0, 4'b1100, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[7] = '{1, 4'b0111, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1, 1'b0};
    vecs[8] = '{0, 4'b1111, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1, 1'b1};

    rst_i = 1'b1;
    clear_reqs();
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    req_ctrl_0 = 4'd0; req_ctrl_1 = 4'd0;
    req_src1_0 = 32'd0; req_src2_0 = 32'd0; req_src1_1 = 32'd0; req_src2_1 = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", rsp_result | alu_src1 | alu_src2 | {28'd0, alu_ctrl}, 32'd0);
    chk("reset_flags", {26'd0, rsp_zero, rsp_err, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1}, 32'd0);
    rst_i = 1'b0;

    // Directed vectors
    for (int i = 0; i < 9; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].ctrl, vecs[i].s1, vecs[i].s2,
             vecs[i].res, vecs[i].zero, vecs[i].err);

    // Randomized operations against the reference model
    for (int i = 0; i < 30; i++) begin
      rp = $urandom_range(0, 1);
      rc = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      rr = ref_result(rc, ra, rb);
      do_txn($sformatf("rand%0d", i), rp, rc, ra, rb, rr, rr == 32'd0, ~is_legal(rc));
    end

    // Contention: both ports hold valid continuously
    do_reset();
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    set_req(0, 4'b0010, 32'd1, 32'd1);
    set_req(1, 4'b0010, 32'd2, 32'd2);
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req_ready_0 | req_ready_1) && n < 8) begin
        @(negedge clk); n++;
      end
      g = req_ready_1;
`ifdef ALU_ARB_RR_EN
      chk($sformatf("contend_grant%0d", k), {31'd0, g}, {31'd0, exp_ptr});
      exp_ptr = ~g;
`else
      chk($sformatf("contend_grant%0d", k), {31'd0, g}, 32'd0);
`endif
      chk($sformatf("contend_onehot%0d", k), {31'd0, req_ready_0 & req_ready_1}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("contend_rsp%0d", k), {30'd0, rsp_valid_0, rsp_valid_1}, g ? 32'd1 : 32'd2);
      chk($sformatf("contend_res%0d", k), rsp_result, g ? 32'd4 : 32'd2);
    end
    @(negedge clk);
    clear_reqs();
    repeat (3) @(negedge clk);

    // Response back-pressure; a second requester comes and goes meanwhile
    @(negedge clk);
    rsp_ready_0 = 1'b0;
    set_req(0, 4'b0010, 32'd10, 32'd20);
    #1;
    chk("stall_accept", {31'd0, req_ready_0}, 32'd1);
    @(negedge clk);
    clear_reqs();
    set_req(1, 4'b0110, 32'd5, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_valid%0d", k), {30'd0, rsp_valid_0, rsp_valid_1}, 32'd2);
      chk($sformatf("stall_result%0d", k), rsp_result, 32'd30);
      chk($sformatf("stall_ready%0d", k), {30'd0, req_ready_0, req_ready_1}, 32'd0);
    end
    req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("dropped_valid%0d", k), {30'd0, rsp_valid_0, rsp_valid_1}, 32'd0);
      chk($sformatf("dropped_alu%0d", k), alu_src1 | {28'd0, alu_ctrl}, 32'd0);
    end

    // Reset while the ALU is being driven aborts the transaction
    @(negedge clk);
    set_req(1, 4'b0001, 32'h0000_00AA, 32'h0000_0055);
    #1;
    chk("abort_accept", {31'd0, req_ready_1}, 32'd1);
    @(negedge clk);
    clear_reqs();
    chk("abort_issue_src", alu_src1, 32'h0000_00AA);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort_outputs", rsp_result | alu_src1 | alu_src2 | {28'd0, alu_ctrl}, 32'd0);
    chk("abort_flags", {26'd0, rsp_zero, rsp_err, rsp_valid_0, rsp_valid_1, req_ready_0, req_ready_1}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abort_no_rsp%0d", k), {30'd0, rsp_valid_0, rsp_valid_1}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
